// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I micro-ops (op/rs1/rs2/rd/imm via in_valid/in_ready, start/base_addr) into words written on mem_we/mem_addr/mem_wdata; status busy/done/err/err_addr/ovf
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        op,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              ovf
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] addr_q, err_addr_q;
  logic [31:0] wdata_q, word_d;
  logic in_ready_q, we_q, busy_q, done_q, err_q, ovf_q, last_q, legal_d;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [11:0] i_imm;
  always_comb begin
    f3 = op[2:0];
    f7 = {1'b0, op[4], 5'b0};
    i_imm = f3[1:0] == 2'b01 ? {f7, imm[4:0]} : imm[11:0];
    word_d = '0;
    legal_d = 1'b0;
    if (op == 6'b0) begin
      legal_d = 1'b1;
    end else if (op[3] && op[5]) begin
      legal_d = !op[4] || f3 == 3'b000 || f3 == 3'b101;
      word_d = {f7, rs2, rs1, f3, rd, 7'b0110011};
    end else if (op[3]) begin
      legal_d = !op[4] || f3 == 3'b101;
      word_d = {i_imm, rs1, f3, rd, 7'b0010011};
    end else begin
      case (op[5:4])
        2'b01: begin
          legal_d = !(f3 == 3'b011 || f3[2:1] == 2'b11);
          word_d = {imm[11:0], rs1, f3, rd, 7'b0000011};
        end
        2'b11: begin
          legal_d = f3 < 3'b011;
          word_d = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
        end
        2'b10: begin
          legal_d = f3[2:1] != 2'b01 && !imm[0];
          word_d = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
        end
        default: begin
          case (f3)
            3'b100: begin
              legal_d = 1'b1;
              word_d = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            3'b101: begin
              legal_d = !imm[0];
              word_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            end
            3'b010: begin
              legal_d = 1'b1;
              word_d = {imm[31:12], rd, 7'b0010111};
            end
            3'b110: begin
              legal_d = 1'b1;
              word_d = {imm[31:12], rd, 7'b0110111};
            end
            default: legal_d = 1'b0;
          endcase
        end
      endcase
    end
    if (!legal_d) word_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      err_addr_q <= '0;
      wdata_q <= '0;
      in_ready_q <= 1'b0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= ACCEPT;
          addr_q <= base_addr;
          in_ready_q <= 1'b1;
          busy_q <= 1'b1;
          err_q <= 1'b0;
          ovf_q <= 1'b0;
        end
        ACCEPT: if (in_valid) begin
          state_q <= WRITE;
          in_ready_q <= 1'b0;
          we_q <= 1'b1;
          wdata_q <= word_d;
          last_q <= in_last;
          if (!legal_d) err_q <= 1'b1;
          if (!legal_d && !err_q) err_addr_q <= addr_q;
        end
        WRITE: begin
          we_q <= 1'b0;
          if (last_q || &addr_q) begin
            state_q <= DONE;
            done_q <= 1'b1;
            ovf_q <= !last_q;
          end else begin
            state_q <= ACCEPT;
            addr_q <= addr_q + 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign err_addr = err_addr_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table vectors plus randomized programs checked against a field-level encoding model
module tb_instr_encoder;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
  logic [9:0] base_addr = 0;
  logic [5:0] op = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [31:0] imm = 0;
  logic in_ready, mem_we, busy, done, err, ovf;
  logic [9:0] mem_addr, err_addr;
  logic [31:0] mem_wdata;
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_we_cyc = 0;
  typedef struct packed {logic [5:0] op; logic [4:0] rs1, rs2, rd; logic [31:0] imm;} uop_t;
  typedef struct packed {uop_t u; logic [31:0] exp;} vec_t;
  typedef struct packed {logic [9:0] a; logic [31:0] w;} wr_t;
  wr_t wq[$];
  vec_t tbl[8];
  always #5 clk = ~clk;
  instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .ovf(ovf)
  );
  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wq.push_back('{mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Returns {legal, word}; built field by field from the RV32I instruction formats.
  function automatic logic [32:0] model(input uop_t u);
    logic [31:0] f3 = 32'(u.op[2:0]);
    logic [31:0] a = 32'(u.rs1);
    logic [31:0] b = 32'(u.rs2);
    logic [31:0] d = 32'(u.rd);
    logic [31:0] im = u.imm;
    logic [31:0] alt = u.op[4] ? 32'h20 : 32'h0;
    logic [31:0] w = 0;
    bit ok = 0;
    if (u.op == 0) ok = 1;
    else if (u.op[3] && u.op[5]) begin
      ok = !u.op[4] || f3 == 0 || f3 == 5;
      w = (alt << 25) | (b << 20) | (a << 15) | (f3 << 12) | (d << 7) | 32'h33;
    end else if (u.op[3]) begin
      ok = !u.op[4] || f3 == 5;
      w = (((f3 == 1 || f3 == 5) ? ((alt << 5) | (im & 31)) : (im & 32'hFFF)) << 20)
          | (a << 15) | (f3 << 12) | (d << 7) | 32'h13;
    end else if (u.op[5:3] == 3'b010) begin
      ok = !(f3 inside {3, 6, 7});
      w = ((im & 32'hFFF) << 20) | (a << 15) | (f3 << 12) | (d << 7) | 32'h03;
    end else if (u.op[5:3] == 3'b110) begin
      ok = f3 < 3;
      w = (((im >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f3 << 12) | ((im & 31) << 7) | 32'h23;
    end else if (u.op[5:3] == 3'b100) begin
      ok = !(f3 inside {2, 3}) && !im[0];
      w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (b << 20) | (a << 15) | (f3 << 12)
          | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
    end else if (f3 == 4) begin
      ok = 1;
      w = ((im & 32'hFFF) << 20) | (a << 15) | (d << 7) | 32'h67;
    end else if (f3 == 5) begin
      ok = !im[0];
      w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
          | (((im >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
    end else if (f3 == 2 || f3 == 6) begin
      ok = 1;
      w = (im & 32'hFFFFF000) | (d << 7) | (f3 == 2 ? 32'h17 : 32'h37);
    end
    return {ok, ok ? w : 32'h0};
  endfunction
  task automatic start_prog(input logic [9:0] b);
    @(negedge clk);
    start = 1;
    base_addr = b;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input uop_t u, input bit last, input bit gaps);
    int t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        start = 1'($urandom_range(0, 1));
        base_addr = 10'($urandom);
        @(negedge clk);
      end
      start = 0;
    end
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL in_ready_wait: got 0 expected 1");
      return;
    end
    {op, rs1, rs2, rd, imm} = u;
    in_valid = 1;
    in_last = last;
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
    if (gaps && !last) begin
      in_valid = 1;
      op = 6'($urandom);
      imm = $urandom;
      @(negedge clk);
      in_valid = 0;
    end
  endtask
  task automatic run_prog(input logic [9:0] b, input uop_t p[$], input bit gaps);
    logic [9:0] a = b;
    logic [9:0] ea = 0;
    bit e = 0, o = 0;
    wr_t exp[$];
    int c0 = done_cnt;
    int t = 0;
    for (int i = 0; i < p.size(); i++) begin
      logic [32:0] m = model(p[i]);
      exp.push_back('{a, m[31:0]});
      if (!m[32] && !e) begin
        e = 1;
        ea = a;
      end
      if (a == 10'h3FF && i != p.size() - 1) begin
        o = 1;
        break;
      end
      a++;
    end
    wq.delete();
    start_prog(b);
    chk("err_cleared_on_start", {31'b0, err}, 0);
    chk("ovf_cleared_on_start", {31'b0, ovf}, 0);
    for (int i = 0; i < exp.size(); i++) send(p[i], i == p.size() - 1, gaps);
    while (done_cnt == c0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - c0), 1);
    chk("done_after_last_write", 32'(done_cyc - last_we_cyc), 1);
    chk("busy_after_done", {31'b0, busy}, 0);
    chk("write_count", 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
      chk("write_addr", 32'(wq[i].a), 32'(exp[i].a));
      chk("write_word", wq[i].w, exp[i].w);
    end
    chk("err_flag", {31'b0, err}, {31'b0, e});
    chk("ovf_flag", {31'b0, ovf}, {31'b0, o});
    if (e) chk("err_addr", 32'(err_addr), 32'(ea));
  endtask
  initial begin
    uop_t p[$];
    tbl[0] = '{'{6'b101000, 5'd1, 5'd2, 5'd3, 32'd0}, 32'h002081B3};
    tbl[1] = '{'{6'b111000, 5'd1, 5'd2, 5'd3, 32'd0}, 32'h402081B3};
    tbl[2] = '{'{6'b001000, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF}, 32'hFFF00293};
    tbl[3] = '{'{6'b011101, 5'd2, 5'd0, 5'd1, 32'd3}, 32'h40315093};
    tbl[4] = '{'{6'b110010, 5'd1, 5'd2, 5'd0, 32'd8}, 32'h0020A423};
    tbl[5] = '{'{6'b100000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC}, 32'hFE208EE3};
    tbl[6] = '{'{6'b000110, 5'd0, 5'd0, 5'd7, 32'h12345000}, 32'h123453B7};
    tbl[7] = '{'{6'b000101, 5'd0, 5'd0, 5'd1, 32'd8}, 32'h008000EF};
    repeat (2) @(negedge clk);
    chk("reset_we_ready_busy_done", {28'b0, mem_we, in_ready, busy, done}, 0);
    chk("reset_err_ovf", {30'b0, err, ovf}, 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_err_addr", 32'(err_addr), 0);
    rst_n = 1;
    p = '{tbl[0].u, tbl[1].u, tbl[2].u};
    run_prog(10'h010, p, 0);
    for (int i = 0; i < 3 && i < wq.size(); i++) chk("table_prog1", wq[i].w, tbl[i].exp);
    p = '{tbl[3].u, tbl[4].u, tbl[5].u, tbl[6].u, tbl[7].u};
    run_prog(10'h040, p, 1);
    for (int i = 0; i < 5 && i < wq.size(); i++) chk("table_prog2", wq[i].w, tbl[i + 3].exp);
    p = '{tbl[0].u, tbl[1].u, '{6'b000111, 5'd1, 5'd2, 5'd3, 32'd0},
          '{6'b111001, 5'd1, 5'd2, 5'd3, 32'd0}, tbl[2].u};
    run_prog(10'h020, p, 0);
    chk("illegal_err_addr_first", 32'(err_addr), 32'h022);
    chk("illegal_word_zero", wq.size() > 2 ? wq[2].w : 32'hDEAD, 0);
    p = '{tbl[6].u};
    run_prog(10'h030, p, 0);
    chk("err_cleared_after_clean_prog", {31'b0, err}, 0);
    p = '{tbl[0].u, tbl[1].u, tbl[3].u};
    run_prog(10'h3FE, p, 0);
    chk("ovf_set_at_top", {31'b0, ovf}, 1);
    in_valid = 1;
    {op, rs1, rs2, rd, imm} = tbl[0].u;
    repeat (5) @(negedge clk);
    chk("no_accept_after_ovf", 32'(wq.size()), 2);
    chk("ready_low_after_ovf", {31'b0, in_ready}, 0);
    in_valid = 0;
    for (int n = 0; n < 10; n++) begin
      p.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) begin
        uop_t u;
        u.op = $urandom_range(0, 1) ? 6'($urandom) : tbl[$urandom_range(0, 7)].u.op;
        u.rs1 = 5'($urandom);
        u.rs2 = 5'($urandom);
        u.rd = 5'($urandom);
        u.imm = $urandom;
        if ($urandom_range(0, 1)) u.imm[0] = 0;
        p.push_back(u);
      end
      run_prog(n == 9 ? 10'h3FC : 10'($urandom_range(0, 10'h3F0)), p, 1);
    end
    start_prog(10'h100);
    while (!in_ready) @(negedge clk);
    {op, rs1, rs2, rd, imm} = tbl[0].u;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("we_before_reset", {31'b0, mem_we}, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_we", {31'b0, mem_we}, 0);
    chk("async_reset_busy", {31'b0, busy}, 0);
    chk("async_reset_outputs", mem_wdata | 32'(mem_addr) | {31'b0, in_ready}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {30'b0, busy, mem_we}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder and program writer; the inverse of the core's instruction decoder. Accepts decoded micro-ops (6-bit op code plus register fields and immediate) over a valid/ready handshake, packs each into a 32-bit RV32I word and writes it to consecutive instruction-memory word addresses. Used by the test harness and boot loader to build programs in instruction memory before the CPU is released from reset.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a program at base_addr; ignored unless idle
- base_addr  in  ADDR_W  first word address
- in_valid / in_ready  in / out  1  micro-op handshake
- in_last  in  1  marks the final micro-op of the program
- op  in  6  op code, same encoding the decoder produces
- rs1, rs2, rd  in  5 each  register fields
- imm  in  32  signed byte offset or value; LUI/AUIPC use imm[31:12]
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at program end
- err  out  1  sticky illegal-op flag, cleared on accepted start
- err_addr  out  ADDR_W  address of first illegal word
- ovf  out  1  sticky address-overflow flag, cleared on accepted start

## Operation
- op==0: word 0x00000000 (NOP).
- op[3]=1, ALU: op[5]=1 -> opcode 0110011, funct7={0,op[4],00000}; op[5]=0 -> 0010011, imm[11:0]=imm[11:0]; for funct3 x01 imm[11:5]={0,op[4],00000}, imm[4:0]=shamt. funct3=op[2:0].
- op[5:3]=010 load (0000011, I-type); 110 store (0100011, S-type); funct3=op[2:0].
- op[5:3]=100 branch (1100011, B-type from imm[12:1]), funct3=op[2:0].
- op[5:3]=000: op[2:0]=100 JALR (I-type), 101 JAL (J-type from imm[20:1]), 010 AUIPC, 110 LUI; opcode = {1'b?,op[2:0],111} per RV32I (1100111, 1101111, 0010111, 0110111).
- Unused fields are written as zero (rs2 in I-type, rs1/rs2 in U/J, rd in S/B).
- Illegal: any other op; op[4]=1 ALU with funct3 not 000/101 (or not 101 for imm); load funct3 011/110/111; store funct3 >=011; branch funct3 010/011; branch/JAL with imm[0]=1. An illegal op writes 0x00000000, sets err; err_addr captured only on the first illegal op since start.
- FSM: IDLE -(start)-> ACCEPT -(in_valid&&in_ready)-> WRITE -> ACCEPT, or DONE if in_last or overflow -> IDLE.
- Address counter loaded with base_addr on start, increments after each WRITE. Writing at address 2^ADDR_W-1 with in_last=0: ovf set, go to DONE; no wrap.

## Timing
- Reset: state IDLE, all outputs 0 (mem_addr, mem_wdata, err_addr included).
- in_ready=1 only in ACCEPT. Accepted op is encoded and registered at that edge; mem_we=1 for exactly the following cycle (WRITE) with mem_addr/mem_wdata stable. Throughput 1 word / 2 cycles.
- done=1 for the single DONE cycle; busy drops the cycle after.
- start while busy: ignored. in_valid in IDLE/WRITE/DONE: not accepted.
- rst_n low mid-program: immediate return to IDLE, mem_we deasserts asynchronously, flags cleared.

## Test plan
- start base 0x010; ADD x3,x1,x2 (op 101000), SUB (111000), ADDI x5,x0,-1 (001000, last) -> writes 0x002081B3@0x010, 0x402081B3@0x011, 0xFFF00293@0x012; done one cycle after last write.
- SRAI x1,x2,3 (011101), SW x2,8(x1) (110010), BEQ x1,x2,-4 (100000), LUI x7,0x12345000 (000110), JAL x1,+8 (000101) -> 0x40315093, 0x0020A423, 0xFE208EE3, 0x123453B7, 0x008000EF.
- op 000111 at third word, base 0x020 -> writes 0x0 @0x022, err=1, err_addr=0x022; later illegal leaves err_addr; next start clears err.
- base 0x3FE, three ops without in_last -> writes @0x3FE, 0x3FF, ovf=1, done, third op never accepted.
- in_valid gaps and start pulses while busy -> no extra writes, addresses contiguous.
- rst_n low during WRITE -> mem_we 0 immediately, busy 0, outputs zero.
